// File: rtl/issue_pkg.sv
// Shared types and sizes for the issue/acknowledge responder and its lanes.
package issue_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_IDX_W     = 5;

    typedef enum logic {
        LANE_IDLE = 1'b0,
        LANE_MUL  = 1'b1
    } lane_state_t;
endpackage

// File: rtl/exec_lane.sv
// One issue lane: accepts single-cycle or multi-cycle ops, times multiplies
// and produces the raw writeback plus scoreboard set/clear strobes.
module exec_lane
    import issue_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [REG_IDX_W-1:0] i_regd,
    input  logic                 i_mul,
    input  logic [XLEN-1:0]      i_result,
    output logic                 o_ack,
    output logic                 o_wb_en,
    output logic [REG_IDX_W-1:0] o_wb_regd,
    output logic [XLEN-1:0]      o_wb_data,
    output logic                 o_set,
    output logic [REG_IDX_W-1:0] o_set_idx,
    output logic                 o_clr,
    output logic [REG_IDX_W-1:0] o_clr_idx
);
    localparam int             CW       = $clog2(MUL_LAT);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(MUL_LAT - 2);

    lane_state_t          r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [REG_IDX_W-1:0] r_mul_regd, w_mul_regd_nxt;
    logic                 r_wb_en, w_wb_en_nxt;
    logic [REG_IDX_W-1:0] r_wb_regd, w_wb_regd_nxt;
    logic [XLEN-1:0]      r_wb_data, w_wb_data_nxt;
    logic                 r_mul_wb, w_mul_wb_nxt;
    logic                 w_accept;

    assign o_ack     = (r_state == LANE_IDLE);
    assign w_accept  = i_en & o_ack;
    assign o_wb_en   = r_wb_en;
    assign o_wb_regd = r_wb_regd;
    assign o_wb_data = r_wb_data;
    assign o_set_idx = i_regd;
    // Clear lands the cycle after a multiply's writeback cycle.
    assign o_clr     = r_mul_wb;
    assign o_clr_idx = r_wb_regd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LANE_IDLE;
            r_cnt      <= '0;
            r_mul_regd <= '0;
            r_wb_en    <= 1'b0;
            r_wb_regd  <= '0;
            r_wb_data  <= '0;
            r_mul_wb   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mul_regd <= w_mul_regd_nxt;
            r_wb_en    <= w_wb_en_nxt;
            r_wb_regd  <= w_wb_regd_nxt;
            r_wb_data  <= w_wb_data_nxt;
            r_mul_wb   <= w_mul_wb_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mul_regd_nxt = r_mul_regd;
        w_wb_en_nxt    = 1'b0;
        w_wb_regd_nxt  = r_wb_regd;
        w_wb_data_nxt  = r_wb_data;
        w_mul_wb_nxt   = 1'b0;
        o_set          = 1'b0;
        case (r_state)
            LANE_IDLE: begin
                if (w_accept && i_mul) begin
                    w_mul_regd_nxt = i_regd;
                    w_cnt_nxt      = CNT_LOAD;
                    w_state_nxt    = LANE_MUL;
                    o_set          = (i_regd != '0);
                end else if (w_accept) begin
                    w_wb_en_nxt   = (i_regd != '0);
                    w_wb_regd_nxt = i_regd;
                    w_wb_data_nxt = i_result;
                end
            end
            LANE_MUL: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = LANE_IDLE;
                    w_wb_en_nxt   = (r_mul_regd != '0);
                    w_wb_regd_nxt = r_mul_regd;
                    w_wb_data_nxt = i_result;
                    w_mul_wb_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = LANE_IDLE;
        endcase
    end
endmodule

// File: rtl/issue_ack_unit.sv
// Two-lane issue responder: per-lane timing, same-destination writeback
// arbitration and the pending-multiply destination scoreboard.
module issue_ack_unit
    import issue_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en1,
    input  logic                     en2,
    input  logic [REG_IDX_W-1:0]     regd1,
    input  logic [REG_IDX_W-1:0]     regd2,
    input  logic                     mul1,
    input  logic                     mul2,
    input  logic [XLEN-1:0]          result1,
    input  logic [XLEN-1:0]          result2,
    output logic                     ack1,
    output logic                     ack2,
    output logic                     wb_en1,
    output logic                     wb_en2,
    output logic [REG_IDX_W-1:0]     wb_regd1,
    output logic [REG_IDX_W-1:0]     wb_regd2,
    output logic [XLEN-1:0]          wb_data1,
    output logic [XLEN-1:0]          wb_data2,
    output logic [NUM_ARCH_REGS-1:0] pending
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]                w_en, w_mul, w_ack, w_wb_en, w_set, w_clr;
    logic [NUM_LANES-1:0][REG_IDX_W-1:0] w_regd, w_wb_regd, w_set_idx, w_clr_idx;
    logic [NUM_LANES-1:0][XLEN-1:0]      w_result, w_wb_data;
    logic [NUM_ARCH_REGS-1:0]            r_pending, w_set_mask, w_clr_mask;
    logic                                w_conflict;

    assign w_en     = {en2, en1};
    assign w_mul    = {mul2, mul1};
    assign w_regd   = {regd2, regd1};
    assign w_result = {result2, result1};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        exec_lane #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_en     (w_en[g]),
            .i_regd   (w_regd[g]),
            .i_mul    (w_mul[g]),
            .i_result (w_result[g]),
            .o_ack    (w_ack[g]),
            .o_wb_en  (w_wb_en[g]),
            .o_wb_regd(w_wb_regd[g]),
            .o_wb_data(w_wb_data[g]),
            .o_set    (w_set[g]),
            .o_set_idx(w_set_idx[g]),
            .o_clr    (w_clr[g]),
            .o_clr_idx(w_clr_idx[g])
        );
    end

    // Lane 2 carries the younger instruction, so it owns a shared destination.
    assign w_conflict = w_wb_en[1] & (w_wb_regd[0] == w_wb_regd[1]);

    assign ack1     = w_ack[0];
    assign ack2     = w_ack[1];
    assign wb_en1   = w_wb_en[0] & ~w_conflict;
    assign wb_en2   = w_wb_en[1];
    assign wb_regd1 = w_wb_regd[0];
    assign wb_regd2 = w_wb_regd[1];
    assign wb_data1 = w_wb_data[0];
    assign wb_data2 = w_wb_data[1];
    assign pending  = r_pending;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_set[l]) w_set_mask[w_set_idx[l]] = 1'b1;
            if (w_clr[l]) w_clr_mask[w_clr_idx[l]] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle set of the same bit wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pending <= '0;
        else      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
endmodule

// File: tb/tb_issue_ack_unit.sv
// Directed and random stimulus against a cycle-indexed event model of the
// issue/ack handshake, writeback arbitration and pending scoreboard.
module tb_issue_ack_unit;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 4;
    localparam int NC      = 2048;

    logic        clk, rst;
    logic        en1, en2, mul1, mul2;
    logic [4:0]  regd1, regd2;
    logic [31:0] result1, result2;
    logic        ack1, ack2, wb_en1, wb_en2;
    logic [4:0]  wb_regd1, wb_regd2;
    logic [31:0] wb_data1, wb_data2;
    logic [31:0] pending;

    issue_ack_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .en1(en1), .en2(en2), .regd1(regd1), .regd2(regd2),
        .mul1(mul1), .mul2(mul2), .result1(result1), .result2(result2),
        .ack1(ack1), .ack2(ack2), .wb_en1(wb_en1), .wb_en2(wb_en2),
        .wb_regd1(wb_regd1), .wb_regd2(wb_regd2),
        .wb_data1(wb_data1), .wb_data2(wb_data2), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: expected writebacks indexed by cycle, lane busy horizon,
    // in-flight multiply bookkeeping and the expected scoreboard.
    bit          exp_en [2][NC];
    logic [4:0]  exp_rg [2][NC];
    logic [31:0] exp_dt [2][NC];
    int          free_at [2];
    bit          mul_act [2];
    int          mul_wb  [2];
    logic [4:0]  mul_dst [2];
    logic [31:0] exp_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            free_at[n] = 0;
            mul_act[n] = 1'b0;
            for (int c = cyc; c < NC; c++) exp_en[n][c] = 1'b0;
        end
        exp_pend = '0;
    endtask

    task automatic check_outputs();
        bit e0, e1;
        e0 = exp_en[0][cyc];
        e1 = exp_en[1][cyc];
        if (e0 && e1 && exp_rg[0][cyc] == exp_rg[1][cyc]) e0 = 1'b0;
        chk("ack1", 32'(ack1), 32'(cyc >= free_at[0]));
        chk("ack2", 32'(ack2), 32'(cyc >= free_at[1]));
        chk("wb_en1", 32'(wb_en1), 32'(e0));
        chk("wb_en2", 32'(wb_en2), 32'(e1));
        if (e0) begin
            chk("wb_regd1", 32'(wb_regd1), 32'(exp_rg[0][cyc]));
            chk("wb_data1", wb_data1, exp_dt[0][cyc]);
        end
        if (e1) begin
            chk("wb_regd2", 32'(wb_regd2), 32'(exp_rg[1][cyc]));
            chk("wb_data2", wb_data2, exp_dt[1][cyc]);
        end
        chk("pending", pending, exp_pend);
    endtask

    // One cycle: check this cycle's outputs, drive inputs, advance the model.
    task automatic step(input logic [1:0] e, input logic [1:0] m,
                        input logic [4:0] d0, input logic [4:0] d1,
                        input logic [31:0] r0, input logic [31:0] r1);
        logic [4:0]  d [2];
        logic [31:0] r [2];
        logic [31:0] setm, clrm;
        check_outputs();
        en1 = e[0]; en2 = e[1]; mul1 = m[0]; mul2 = m[1];
        regd1 = d0; regd2 = d1; result1 = r0; result2 = r1;
        d[0] = d0; d[1] = d1; r[0] = r0; r[1] = r1;
        setm = '0; clrm = '0;
        for (int n = 0; n < 2; n++) begin
            if (mul_act[n] && cyc == mul_wb[n] - 1) begin
                exp_en[n][cyc+1] = (mul_dst[n] != 0);
                exp_rg[n][cyc+1] = mul_dst[n];
                exp_dt[n][cyc+1] = r[n];
            end
            if (mul_act[n] && cyc == mul_wb[n]) begin
                clrm[mul_dst[n]] = 1'b1;
                mul_act[n] = 1'b0;
            end
            if (e[n] && cyc >= free_at[n]) begin
                if (m[n]) begin
                    free_at[n] = cyc + MUL_LAT;
                    mul_act[n] = 1'b1;
                    mul_wb[n]  = cyc + MUL_LAT;
                    mul_dst[n] = d[n];
                    if (d[n] != 0) setm[d[n]] = 1'b1;
                end else begin
                    exp_en[n][cyc+1] = (d[n] != 0);
                    exp_rg[n][cyc+1] = d[n];
                    exp_dt[n][cyc+1] = r[n];
                end
            end
        end
        exp_pend = (exp_pend & ~clrm) | setm;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    // Reset asserted mid-cycle, held while the scheduler keeps requesting.
    task automatic hold_reset(input int n);
        rst = 1'b0;
        en1 = 1'b1; en2 = 1'b1; mul1 = 1'b1; mul2 = 1'b0;
        regd1 = 5'd3; regd2 = 5'd4;
        #1;
        for (int i = 0; i <= n; i++) begin
            chk("rst_ack1", 32'(ack1), 32'd1);
            chk("rst_ack2", 32'(ack2), 32'd1);
            chk("rst_wb_en", 32'({wb_en2, wb_en1}), 32'd0);
            chk("rst_pending", pending, 32'd0);
            if (i < n) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                #1;
            end
        end
        @(negedge clk);
        cyc++;
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        en1 = 0; en2 = 0; mul1 = 0; mul2 = 0;
        regd1 = 0; regd2 = 0; result1 = 0; result2 = 0;
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < NC; c++) begin
                exp_en[n][c] = 1'b0; exp_rg[n][c] = '0; exp_dt[n][c] = '0;
            end
        model_reset();
        @(negedge clk);
        hold_reset(2);

        // Single-cycle op on lane 1, then back-to-back single-cycle ops.
        step(2'b01, 2'b00, 5'd5, 5'd0, 32'h11, 32'h0);
        step(2'b01, 2'b00, 5'd6, 5'd0, 32'h22, 32'h0);
        idle(2);

        // Multiply to r7 with en1 held high: next accept only when ack returns.
        step(2'b01, 2'b01, 5'd7, 5'd0, 32'h0, 32'h0);
        step(2'b01, 2'b00, 5'd8, 5'd0, 32'h1111, 32'h0);
        step(2'b01, 2'b00, 5'd8, 5'd0, 32'h2222, 32'h0);
        step(2'b01, 2'b00, 5'd8, 5'd0, 32'hABCD, 32'h0);
        step(2'b01, 2'b00, 5'd8, 5'd0, 32'h3333, 32'h0);
        idle(3);

        // Same destination on both lanes: lane 2 wins.
        step(2'b11, 2'b00, 5'd9, 5'd9, 32'h1, 32'h2);
        idle(2);

        // Multiply to r0 on lane 2: timed, never pending, never written.
        step(2'b10, 2'b10, 5'd0, 5'd0, 32'h0, 32'h55);
        idle(MUL_LAT + 1);

        // Back-to-back multiplies to the same register: set wins over clear.
        step(2'b01, 2'b01, 5'd12, 5'd0, 32'h0, 32'h0);
        idle(MUL_LAT - 1);
        step(2'b01, 2'b01, 5'd12, 5'd0, 32'h77, 32'h0);
        idle(MUL_LAT + 1);

        // Reset in the middle of an in-flight multiply.
        step(2'b11, 2'b01, 5'd10, 5'd11, 32'h0, 32'h5);
        idle(1);
        hold_reset(2);
        idle(MUL_LAT + 2);

        for (int i = 0; i < 800; i++) begin
            logic [1:0] e, m;
            e = {1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6)};
            m = {1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 3)};
            step(e, m, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom, $urandom);
        end
        idle(MUL_LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_ack_unit.md
# issue_ack_unit

Responder side of the scheduler's issue handshake: accepts one instruction per lane per cycle when it drives `ack1`/`ack2` high. It tracks single-cycle and multi-cycle (multiply) operations, returns the acknowledge when a lane is free again, and emits per-lane register-file writeback strobes. It also exports a pending-destination scoreboard for dependency checks. It sits between the two execution lanes (ALU outputs) and the dual-port register file write side.

## Interface
- `XLEN`, 32, datapath width
- `MUL_LAT`, 4, total cycles from multiply accept to its writeback; legal range ≥ 2
- `clk  in  1  system clock, rising edge`
- `rst  in  1  reset, asynchronous, active-low`
- `en1`, `en2  in  1  issue valid for lane 1 / lane 2 (datapath_N_enable)`
- `regd1`, `regd2  in  5  destination register of issued instruction`
- `mul1`, `mul2  in  1  issued op is multi-cycle (MUL_EN); qualified by enN`
- `result1`, `result2  in  XLEN  lane execution result`
- `ack1`, `ack2  out  1  lane ready; accept = enN & ackN`
- `wb_en1`, `wb_en2  out  1  register-file write strobe`
- `wb_regd1`, `wb_regd2  out  5  write destination`
- `wb_data1`, `wb_data2  out  XLEN  write data`
- `pending  out  32  bit r high = in-flight multiply targets register r`

## Operation
- Per-lane FSM with states LANE_IDLE and LANE_MUL. Each lane has a down-counter of width clog2(MUL_LAT).
- `ackN` = (state == LANE_IDLE).
- In LANE_IDLE, when accepted with `mulN=0`:
  - register `regdN` and `resultN` into the wb outputs;
  - `wb_enN`=1 next cycle;
  - stay in LANE_IDLE, so back-to-back single-cycle accepts are allowed.
- In LANE_IDLE, when accepted with `mulN=1`:
  - latch `regdN`, load counter with MUL_LAT-2, go to LANE_MUL.
- In LANE_MUL:
  - decrement the counter each cycle;
  - when counter == 0, sample `resultN` into `wb_dataN`, assert `wb_enN` next cycle, and return to LANE_IDLE.
- `enN` while `ackN`=0 is ignored. The scheduler holds the instruction until it sees ack.
- `regd` == 0:
  - instruction is still accepted and timed normally;
  - `wb_enN` is forced 0;
  - the pending bit is never set.
- Scoreboard (pending bits):
  - `pending[regd]` is set on the cycle after a multiply accept.
  - It is cleared on the cycle after that lane's `wb_en` cycle.
  - If a set and a clear of the same bit fall in the same cycle, set wins.
- Writeback conflict: if both lanes would assert `wb_en` with equal `wb_regd` in the same cycle, lane 2 wins and `wb_en1` is suppressed. Lane 2 holds the younger instruction.
- Reset (async assert, any time, including mid-multiply):
  - both FSMs go to LANE_IDLE and counters to 0;
  - `pending`=0; all wb outputs are 0;
  - `ack1`=`ack2`=1 while reset is asserted;
  - no accept occurs while reset is asserted.

## Timing
- Single-cycle op accepted at edge t: `wb_en`/`wb_regd`/`wb_data` are valid in cycle t+1, for exactly one cycle.
- Multiply accepted at edge t:
  - `ack` low in cycles t+1 … t+MUL_LAT-1;
  - `result` sampled at the end of cycle t+MUL_LAT-1;
  - `wb_en` high and `ack` high in cycle t+MUL_LAT;
  - `pending` bit high in cycles t+1 … t+MUL_LAT.
- A new accept may occur in the same cycle as the previous multiply's writeback.
- All outputs except `ackN` are registered. `ackN` is decoded directly from the state register.

## Structure
- Package `issue_pkg` holds:
  - `lane_state_t` enum (LANE_IDLE, LANE_MUL);
  - `NUM_ARCH_REGS` = 32;
  - `REG_IDX_W` = 5.
- Sub-module `exec_lane`, instantiated twice. It contains the FSM, counter, wb registers and a raw wb_en output, and produces set/clear strobes for the scoreboard.
- Top `issue_ack_unit` contains the same-destination conflict suppression and the 32-bit scoreboard.

## Test plan
- Reset, then en1=1, regd1=5, mul1=0, result1=0x11 for one cycle → cycle+1: wb_en1=1, wb_regd1=5, wb_data1=0x11; ack1 stays 1 throughout.
- MUL_LAT=4; at t, en1=1, mul1=1, regd1=7; result1=0xABCD during t+3 → ack1 low at t+1..t+3, pending[7] high at t+1..t+4, wb_en1 with data 0xABCD at t+4, ack1 high at t+4, pending[7]=0 at t+5.
- Lane 1 in LANE_MUL with en1 held high → no second accept until ack1 returns; exactly one writeback per accept.
- Both lanes issue single-cycle ops with regd=9 (result1=1, result2=2) → next cycle wb_en2=1 with data 2, wb_en1=0.
- en2=1, regd2=0, mul2=1 → ack2 drops for MUL_LAT-1 cycles, pending stays 0, wb_en2 never asserts.
- rst pulled low at t+2 of an in-flight multiply → immediately ack=1, pending=0, wb_en=0; after release, no late writeback occurs.
